// File: rtl/mux_nto1_scan_if.sv
// Bus bundle for the N-channel scanning mux: control/data inputs plus the
// registered selection result.
interface mux_nto1_scan_if #(
  parameter int N_CH = 8,
  parameter int W    = 1
);
  localparam int SEL_W = $clog2(N_CH);

  logic                en;
  logic                mode;
  logic [SEL_W-1:0]    sel;
  logic [N_CH-1:0]     mask;
  logic [N_CH*W-1:0]   d;
  logic [W-1:0]        y;
  logic [SEL_W-1:0]    y_ch;
  logic                y_valid;
  logic                scan_wrap;

  modport master (
    output en, mode, sel, mask, d,
    input  y, y_ch, y_valid, scan_wrap
  );

  modport slave (
    input  en, mode, sel, mask, d,
    output y, y_ch, y_valid, scan_wrap
  );
endinterface

// File: rtl/mux_nto1_scan.sv
// N-channel W-bit multiplexer with registered output, manual select and an
// auto-scan mode that dwells DWELL cycles on each masked-in channel.
module mux_nto1_scan #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int DWELL = 4
) (
  input logic           clk,
  input logic           rst,
  mux_nto1_scan_if.slave bus
);
  localparam int SEL_W = $clog2(N_CH);
  localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [SEL_W-1:0] ptr;
  logic [DW_W-1:0]  dwell_cnt;
  logic             prev_mode;
  logic             wrap_flag;

  logic [W-1:0]     data_arr [N_CH];
  logic [SEL_W-1:0] ld_ch;
  logic [SEL_W-1:0] out_ch;
  logic             ch_legal;
  logic             ch_on;
  logic [W-1:0]     ch_data;
  logic             dwell_done;
  logic             nxt_found;
  logic [SEL_W-1:0] nxt_ptr;
  int               idx;

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign data_arr[i] = bus.d[i*W +: W];
  end

  // Channel that feeds the output register this cycle: sel in manual mode,
  // the freshly loaded start channel on scan entry, otherwise the pointer.
  always_comb begin
    ld_ch    = (int'(bus.sel) < N_CH) ? bus.sel : '0;
    out_ch   = bus.mode ? (prev_mode ? ptr : ld_ch) : bus.sel;
    ch_legal = int'(out_ch) < N_CH;
    ch_on    = 1'b0;
    ch_data  = '0;
    if (ch_legal) begin
      ch_on   = !bus.mode || bus.mask[out_ch];
      ch_data = data_arr[out_ch];
    end
    dwell_done = (dwell_cnt == DW_W'(DWELL - 1));
  end

  // Circular search for the next enabled channel after ptr; a single enabled
  // channel finds itself after a full lap.
  always_comb begin
    nxt_found = 1'b0;
    nxt_ptr   = ptr;
    idx       = 0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!nxt_found && bus.mask[idx]) begin
        nxt_found = 1'b1;
        nxt_ptr   = SEL_W'(idx);
      end
    end
  end

  // wrap_flag marks an advance that wrapped; it surfaces on scan_wrap one
  // cycle later so the pulse lines up with y_ch showing the new channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr           <= '0;
      dwell_cnt     <= '0;
      prev_mode     <= 1'b0;
      wrap_flag     <= 1'b0;
      bus.y         <= '0;
      bus.y_ch      <= '0;
      bus.y_valid   <= 1'b0;
      bus.scan_wrap <= 1'b0;
    end else if (bus.en) begin
      prev_mode   <= bus.mode;
      bus.y_ch    <= out_ch;
      bus.y_valid <= ch_on;
      bus.y       <= ch_on ? ch_data : '0;
      if (!bus.mode) begin
        bus.scan_wrap <= 1'b0;
        wrap_flag     <= 1'b0;
      end else if (!prev_mode) begin
        ptr           <= ld_ch;
        dwell_cnt     <= '0;
        bus.scan_wrap <= 1'b0;
        wrap_flag     <= 1'b0;
      end else begin
        bus.scan_wrap <= wrap_flag;
        if (dwell_done) begin
          dwell_cnt <= '0;
          if (nxt_found) begin
            ptr       <= nxt_ptr;
            wrap_flag <= (nxt_ptr <= ptr);
          end else begin
            wrap_flag <= 1'b0;
          end
        end else begin
          dwell_cnt <= dwell_cnt + DW_W'(1);
          wrap_flag <= 1'b0;
        end
      end
    end else begin
      bus.scan_wrap <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mux_nto1_scan.sv
// Scoreboard bench for mux_nto1_scan: three configurations driven with directed
// vectors, expected responses queued and checked by an independent monitor.
module tb_mux_nto1_scan;
  typedef struct {
    int         id;
    logic [3:0] y;
    logic [2:0] ch;
    logic       v;
    logic       w;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;

  mux_nto1_scan_if #(.N_CH(8), .W(1)) ia ();
  mux_nto1_scan_if #(.N_CH(6), .W(4)) ib ();
  mux_nto1_scan_if #(.N_CH(8), .W(1)) ic ();

  mux_nto1_scan #(.N_CH(8), .W(1), .DWELL(3)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  mux_nto1_scan #(.N_CH(6), .W(4), .DWELL(4)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  mux_nto1_scan #(.N_CH(8), .W(1), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));

  task automatic apply_stimulus(input int id, input logic [3:0] y, input logic [2:0] ch,
                                input logic v, input logic w);
    exp_t e;
    e.id = id; e.y = y; e.ch = ch; e.v = v; e.w = w;
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_output(input exp_t e);
    logic [3:0] ay;
    logic [2:0] ach;
    logic       av, aw;
    case (e.id)
      0:       begin ay = {3'b000, ia.y}; ach = ia.y_ch; av = ia.y_valid; aw = ia.scan_wrap; end
      1:       begin ay = ib.y;           ach = ib.y_ch; av = ib.y_valid; aw = ib.scan_wrap; end
      default: begin ay = {3'b000, ic.y}; ach = ic.y_ch; av = ic.y_valid; aw = ic.scan_wrap; end
    endcase
    n_compared++;
    if (ay !== e.y || ach !== e.ch || av !== e.v || aw !== e.w) begin
      n_mismatched++;
      $display("[TB] FAIL dut%0d #%0d: got y=%h ch=%0d valid=%b wrap=%b, expected y=%h ch=%0d valid=%b wrap=%b",
               e.id, n_compared, ay, ach, av, aw, e.y, e.ch, e.v, e.w);
    end
  endtask

  // Monitor: one queued expectation per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [7:0] scan_d;
    logic [2:0] scan_ch [17];
    scan_ch = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5,
                3'd7, 3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd2};
    scan_d = 8'b1000_0101;

    ia.en = 1'b1; ia.mode = 1'b1; ia.sel = 3'd0; ia.mask = 8'h00; ia.d = 8'hFF;
    ib.en = 1'b0; ib.mode = 1'b0; ib.sel = 3'd0; ib.mask = 6'h00; ib.d = '0;
    ic.en = 1'b0; ic.mode = 1'b0; ic.sel = 3'd0; ic.mask = 8'h00; ic.d = 8'h00;
    @(negedge clk);

    // Reset dominates en and mode
    rst = 1'b1;
    repeat (2) apply_stimulus(0, 4'h0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0; ia.mode = 1'b0; ia.sel = 3'd3;
    apply_stimulus(0, 4'h1, 3'd3, 1'b1, 1'b0);

    // Manual sweep, one-hot data per channel
    for (int i = 0; i < 8; i++) begin
      ia.sel = 3'(i);
      ia.d = 8'h00;
      apply_stimulus(0, 4'h0, 3'(i), 1'b1, 1'b0);
      ia.d = 8'(1 << i);
      apply_stimulus(0, 4'h1, 3'(i), 1'b1, 1'b0);
    end

    // Six channels, out-of-range selects give invalid zero output
    ib.en = 1'b1; ib.d = 24'h654321;
    ib.sel = 3'd2; apply_stimulus(1, 4'h3, 3'd2, 1'b1, 1'b0);
    ib.sel = 3'd5; apply_stimulus(1, 4'h6, 3'd5, 1'b1, 1'b0);
    ib.sel = 3'd7; apply_stimulus(1, 4'h0, 3'd7, 1'b0, 1'b0);
    ib.sel = 3'd6; apply_stimulus(1, 4'h0, 3'd6, 1'b0, 1'b0);
    ib.en = 1'b0;

    // Masked scan: entry cycle plus three dwell cycles on channel 0, then 2,5,7,0
    ia.d = scan_d; ia.mask = 8'hA5; ia.sel = 3'd0; ia.mode = 1'b0;
    apply_stimulus(0, {3'b000, scan_d[0]}, 3'd0, 1'b1, 1'b0);
    ia.mode = 1'b1;
    for (int i = 0; i < 17; i++)
      apply_stimulus(0, {3'b000, scan_d[scan_ch[i]]}, scan_ch[i], 1'b1, (i == 13));

    // Freeze mid-dwell, then finish the remaining two cycles on channel 2
    ia.en = 1'b0;
    repeat (5) apply_stimulus(0, 4'h1, 3'd2, 1'b1, 1'b0);
    ia.en = 1'b1;
    repeat (2) apply_stimulus(0, 4'h1, 3'd2, 1'b1, 1'b0);
    apply_stimulus(0, 4'h0, 3'd5, 1'b1, 1'b0);

    // All channels masked off: pointer stuck, output invalid
    ia.mask = 8'h00;
    repeat (5) apply_stimulus(0, 4'h0, 3'd5, 1'b0, 1'b0);
    ia.mask = 8'hA5;
    apply_stimulus(0, 4'h0, 3'd5, 1'b1, 1'b0);

    // Reset mid-dwell, then a fresh scan entry at channel 0
    rst = 1'b1;
    apply_stimulus(0, 4'h0, 3'd0, 1'b0, 1'b0);
    rst = 1'b0;
    apply_stimulus(0, 4'h1, 3'd0, 1'b1, 1'b0);
    ia.en = 1'b0;

    // Single enabled channel with DWELL=1 wraps onto itself every cycle
    ic.en = 1'b1; ic.mode = 1'b0; ic.sel = 3'd4; ic.mask = 8'h10; ic.d = 8'h10;
    apply_stimulus(2, 4'h1, 3'd4, 1'b1, 1'b0);
    ic.mode = 1'b1;
    apply_stimulus(2, 4'h1, 3'd4, 1'b1, 1'b0);
    apply_stimulus(2, 4'h1, 3'd4, 1'b1, 1'b0);
    repeat (6) apply_stimulus(2, 4'h1, 3'd4, 1'b1, 1'b1);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
